// File: rtl/phase_arbiter.sv
// phase_arbiter: round-robin phase scheduler with starvation override.
// Optional build macro PED_PRIORITY_EN: pending pedestrian always wins.
module phase_arbiter #(
  parameter logic [15:0] GREEN_TH_S = 16'd30,
  parameter logic [15:0] GREEN_N_S  = 16'd20,
  parameter logic [15:0] PED_S      = 16'd15,
  parameter int          MAX_SKIP   = 3,
  parameter logic [15:0] GAP_CYCLES = 16'd20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        req_th,
  input  logic        req_nn,
  input  logic        req_ns,
  input  logic        req_ped,
  input  logic        grant_ack,
  input  logic        phase_done,
  output logic        grant_valid,
  output logic [1:0]  grant_id,
  output logic [15:0] green_seconds,
  output logic        starved,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_BUSY,
    S_GAP
  } state_t;

  localparam logic [2:0] SKIP_MAX = 3'(MAX_SKIP);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  pend_q;
  logic [2:0]  skip_q [4];
  logic [1:0]  ptr_q;
  logic [15:0] gap_q;
  logic [1:0]  id_q;
  logic [15:0] green_q;
  logic        starved_q;

  logic [3:0]  req_vec;
  logic        accept;
  logic        load;
  logic        gap_last;
  logic [1:0]  sel_id;
  logic        sel_starved;
  logic [15:0] sel_green;
  logic [1:0]  idx;
  logic        found;

  assign req_vec  = {req_ped, req_ns, req_nn, req_th};
  assign accept   = (state_q == S_OFFER) && grant_ack;
  assign gap_last = ({1'b0, gap_q} + 17'd1) >= {1'b0, GAP_CYCLES};

  // pick next phase: starvation override first, else rotate from ptr
  always_comb begin
    sel_id      = ptr_q;
    sel_starved = 1'b0;
    found       = 1'b0;
    idx         = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i] && skip_q[i] == SKIP_MAX) begin
        sel_id      = 2'(i);
        sel_starved = 1'b1;
      end
    end
    if (!sel_starved) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!found && pend_q[idx]) begin
          sel_id = idx;
          found  = 1'b1;
        end
      end
    end
`ifdef PED_PRIORITY_EN
    if (pend_q[3]) begin
      sel_id      = 2'd3;
      sel_starved = 1'b0;
    end
`endif
  end

  // duration lookup for the selected phase
  always_comb begin
    sel_green = GREEN_TH_S;
    unique case (1'b1)
      (sel_id == 2'd0): sel_green = GREEN_TH_S;
      (sel_id == 2'd1),
      (sel_id == 2'd2): sel_green = GREEN_N_S;
      (sel_id == 2'd3): sel_green = PED_S;
      default:          sel_green = GREEN_TH_S;
    endcase
  end

  // next-state logic for offer/run/gap sequencing
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && |pend_q) begin
          state_d = S_OFFER;
          load    = 1'b1;
        end
      end
      S_OFFER: begin
        if (grant_ack)    state_d = S_BUSY;
        else if (!enable) state_d = S_IDLE;
      end
      S_BUSY: begin
        if (phase_done) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register and all-red gap counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_GAP && !gap_last) gap_q <= gap_q + 16'd1;
      else                               gap_q <= '0;
    end
  end

  // request latch, fairness counters and rotation pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < 4; i++) skip_q[i] <= '0;
    end else begin
      if (accept) begin
        pend_q         <= pend_q | (enable ? req_vec : 4'b0);
        pend_q[id_q]   <= 1'b0;
        ptr_q          <= id_q + 2'd1;
      end else begin
        pend_q <= pend_q | (enable ? req_vec : 4'b0);
      end
      for (int i = 0; i < 4; i++) begin
        if (accept) begin
          if (id_q == 2'(i))
            skip_q[i] <= '0;
          else if (pend_q[i] && skip_q[i] < SKIP_MAX)
            skip_q[i] <= skip_q[i] + 3'd1;
        end
      end
`ifdef PED_PRIORITY_EN
      skip_q[3] <= '0;
`endif
    end
  end

  // offer registers, held outside OFFER
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q      <= '0;
      green_q   <= '0;
      starved_q <= 1'b0;
    end else if (load) begin
      id_q      <= sel_id;
      green_q   <= sel_green;
      starved_q <= sel_starved;
    end
  end

  assign grant_valid   = (state_q == S_OFFER);
  assign grant_id      = id_q;
  assign green_seconds = green_q;
  assign starved       = starved_q;
  assign busy          = (state_q == S_BUSY) || (state_q == S_GAP);

endmodule

// File: doc/phase_arbiter.md
# phase_arbiter

Round-robin phase scheduler for the intersection controller. Latches approach-sensor requests (Thevenin, Norton-North, Norton-South) and the pedestrian button, picks the next green phase with starvation protection, and hands it to the main `fsm` through a valid/ack handshake together with the green duration that `fsm` loads into `time_fsm`. It sequences phase order only; light encoding and timing of yellow/red stay in `fsm`.

## Interface
- `GREEN_TH_S`, 16'd30: green duration (seconds) for Thevenin phase.
- `GREEN_N_S`, 16'd20: green duration for either Norton phase.
- `PED_S`, 16'd15: pedestrian walk duration.
- `MAX_SKIP`, 3: grants a pending requester may be passed over before forced service (1..7).
- `GAP_CYCLES`, 16'd20000: all-red idle gap after phase_done, in clock cycles (2 s at 10 kHz).

- `clk` in 1: system clock (10 kHz); one clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: arbitration enable.
- `req_th`, `req_nn`, `req_ns` in 1 each: level sensor requests (STH, SNN, SNS).
- `req_ped` in 1: pedestrian button, one-cycle pulse, already synchronized.
- `grant_ack` in 1: `fsm` accepts the offered phase.
- `phase_done` in 1: one-cycle pulse from `fsm` when the granted phase has fully ended.
- `grant_valid` out 1: phase offer present.
- `grant_id` out 2: 0=TH, 1=NN, 2=NS, 3=PED.
- `green_seconds` out 16: duration for `grant_id`, to `secondsToCount`.
- `starved` out 1: current offer chosen by starvation override.
- `busy` out 1: a granted phase is running or in gap.

## Operation
- Pending latch `pend[3:0]`: bit i set on any edge where enable=1 and request i high; cleared on the accepting edge (OFFER & grant_ack) for `grant_id`; clear wins over set on that edge; a still-high sensor re-latches next edge. With enable=0 requests are not captured; existing pend bits are kept.
- Skip counters `skip[i]` (3 bits): on each accepting edge, every other pending requester increments, saturating at MAX_SKIP; granted requester's counter clears.
- Selection (combinational from registered pend/skip/ptr): if any pending i has skip[i]==MAX_SKIP, lowest such index wins and `starved`=1; else first pending index searching ptr, ptr+1, ... mod 4.
- Pointer `ptr` (2 bits): on accept, ptr ← grant_id+1 mod 4 (3 wraps to 0).
- States:
  - IDLE: enable & |pend → OFFER, registering grant_id, green_seconds, starved.
  - OFFER: grant_valid=1, outputs stable. grant_ack → BUSY. enable=0 → IDLE, no grant, pend unchanged. phase_done ignored.
  - BUSY: busy=1; wait phase_done → GAP. enable ignored (running phase always completes).
  - GAP: busy=1; count GAP_CYCLES edges → IDLE. GAP_CYCLES=0 → IDLE on next edge.
- green_seconds: TH→GREEN_TH_S, NN/NS→GREEN_N_S, PED→PED_S.
- reset (any state, mid-phase included): state IDLE, pend=0, skip=0, ptr=0, gap counter=0.

## Timing
- Reset values: grant_valid=0, grant_id=0, green_seconds=0, starved=0, busy=0.
- Request sampled at edge k → pend set after k → OFFER/grant_valid after edge k+1 (2-edge latency from IDLE).
- grant_ack sampled while grant_valid=1; grant_valid drops after the accepting edge; ack with grant_valid=0 ignored.
- phase_done at edge p → GAP; IDLE after edge p+GAP_CYCLES; next offer earliest p+GAP_CYCLES+1.
- grant_id/green_seconds/starved hold their last value outside OFFER.

## Configuration
- `PED_PRIORITY_EN` defined: pending PED always wins selection, ahead of starvation override and round-robin; ptr still updated. PED skip counter unused (held 0).
- Undefined: PED is the fourth round-robin slot with normal starvation handling as above.

## Test plan
- Reset, req_th held 1, others 0: grant_valid after 2 edges, grant_id=0, green_seconds=30; ack; phase_done → next offer TH again exactly GAP_CYCLES+1 edges later.
- All sensors held 1, req_ped pulsed once, ack immediately each offer: grant order 0,1,2,3,0,1,2 (PED_PRIORITY_EN off); with macro on, PED granted at first offer after its pulse.
- MAX_SKIP=1, ptr forced via prior grants so NS passed once: next offer grant_id=2 with starved=1.
- enable dropped during OFFER: grant_valid=0 next edge, pend unchanged; enable restored → same grant_id re-offered.
- reset asserted in BUSY: all outputs zero next edge; phase_done after that ignored; new request served from ptr=0.
- phase_done pulsed in OFFER, GAP_CYCLES=0: no state change in OFFER; after ack+done, IDLE on following edge.
